// File: rtl/lsu_issue_queue_if.sv
// Interface bundling the dispatch, CDB and LSU issue signals of lsu_issue_queue.
// slave modport: the queue itself. master modport: the dispatch/CDB/LSU side.
interface lsu_issue_queue_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned CDB_COUNT  = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned PAYLOAD_W  = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                              flush_i;
    logic [DISPATCH_W-1:0]             disp_valid_i;
    logic [DISPATCH_W*PAYLOAD_W-1:0]   disp_payload_i;
    logic [DISPATCH_W*DATA_W-1:0]      disp_imm_i;
    logic [DISPATCH_W*2*TAG_W-1:0]     disp_tag_i;
    logic [DISPATCH_W*2-1:0]           disp_rdy_i;
    logic [DISPATCH_W*2*DATA_W-1:0]    disp_data_i;
    logic                              disp_ready_o;
    logic [CDB_COUNT-1:0]              cdb_valid_i;
    logic [CDB_COUNT*TAG_W-1:0]        cdb_tag_i;
    logic [CDB_COUNT*DATA_W-1:0]       cdb_data_i;
    logic                              iss_valid_o;
    logic                              iss_ready_i;
    logic [DATA_W-1:0]                 iss_vaddr_o;
    logic [DATA_W-1:0]                 iss_wdata_o;
    logic [PAYLOAD_W-1:0]              iss_payload_o;
    logic [CNT_W-1:0]                  free_cnt_o;

    modport slave (
        input  flush_i, disp_valid_i, disp_payload_i, disp_imm_i, disp_tag_i,
               disp_rdy_i, disp_data_i, cdb_valid_i, cdb_tag_i, cdb_data_i, iss_ready_i,
        output disp_ready_o, iss_valid_o, iss_vaddr_o, iss_wdata_o, iss_payload_o, free_cnt_o
    );

    modport master (
        output flush_i, disp_valid_i, disp_payload_i, disp_imm_i, disp_tag_i,
               disp_rdy_i, disp_data_i, cdb_valid_i, cdb_tag_i, cdb_data_i, iss_ready_i,
        input  disp_ready_o, iss_valid_o, iss_vaddr_o, iss_wdata_o, iss_payload_o, free_cnt_o
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue: dispatch up to DISPATCH_W ops per cycle, wake up
// missing operands from the CDB, issue the head op through a registered valid/ready port
// with vaddr = src1 + imm and wdata = src0.
// Optional feature macro: LSU_IQ_CDB_BYPASS_EN (forward a head operand straight from the
// CDB into the issue register, saving one cycle). Undefined by default.
module lsu_issue_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned CDB_COUNT  = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned PAYLOAD_W  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_issue_queue_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Entry storage
    logic                 ent_valid   [DEPTH];
    logic [PAYLOAD_W-1:0] ent_payload [DEPTH];
    logic [DATA_W-1:0]    ent_imm     [DEPTH];
    logic [TAG_W-1:0]     ent_tag     [DEPTH][2];
    logic                 ent_rdy     [DEPTH][2];
    logic [DATA_W-1:0]    ent_data    [DEPTH][2];

    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     free_cnt;

    // Issue output register
    logic                 iss_valid;
    logic [DATA_W-1:0]    iss_vaddr, iss_wdata;
    logic [PAYLOAD_W-1:0] iss_payload;

    // Unpacked CDB views
    logic                 cdb_v [CDB_COUNT];
    logic [TAG_W-1:0]     cdb_t [CDB_COUNT];
    logic [DATA_W-1:0]    cdb_d [CDB_COUNT];

    // Wakeup results per entry/source
    logic                 wake_hit  [DEPTH][2];
    logic [DATA_W-1:0]    wake_data [DEPTH][2];

    // Dispatch lane decode
    logic                 disp_ready;
    logic                 lane_we   [DISPATCH_W];
    logic [PTR_W-1:0]     lane_idx  [DISPATCH_W];
    logic [TAG_W-1:0]     lane_tag  [DISPATCH_W][2];
    logic                 lane_hit  [DISPATCH_W][2];
    logic [DATA_W-1:0]    lane_cdb  [DISPATCH_W][2];
    logic                 lane_rdy  [DISPATCH_W][2];
    logic [DATA_W-1:0]    lane_data [DISPATCH_W][2];
    logic [CNT_W-1:0]     accepted;

    // Head issue decision
    logic                 head_src_rdy [2];
    logic [DATA_W-1:0]    head_src     [2];
    logic                 head_ok;
    logic                 iss_load;

    // Search from the highest channel down so the lowest matching channel wins.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) begin
            if (cdb_v[CDB_COUNT-1-k] && cdb_t[CDB_COUNT-1-k] == tag)
                r = {1'b1, cdb_d[CDB_COUNT-1-k]};
        end
        return r;
    endfunction

    // Split the flattened CDB buses into per-channel fields
    always_comb begin
        for (int unsigned ch = 0; ch < CDB_COUNT; ch++) begin
            cdb_v[ch] = bus.cdb_valid_i[ch];
            cdb_t[ch] = bus.cdb_tag_i[ch*TAG_W +: TAG_W];
            cdb_d[ch] = bus.cdb_data_i[ch*DATA_W +: DATA_W];
        end
    end

    // Tag match of every waiting entry source against the CDB
    always_comb begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                wake_hit[e][s]  = 1'b0;
                wake_data[e][s] = '0;
                if (ent_valid[e] && !ent_rdy[e][s])
                    {wake_hit[e][s], wake_data[e][s]} = cdb_lookup(ent_tag[e][s]);
            end
        end
    end

    assign disp_ready = (free_cnt >= CNT_W'(DISPATCH_W));

    // Compact valid lanes into consecutive slots from tail; capture same-cycle CDB values
    always_comb begin
        accepted = '0;
        for (int unsigned l = 0; l < DISPATCH_W; l++) begin
            lane_we[l]  = disp_ready && bus.disp_valid_i[l];
            lane_idx[l] = tail + PTR_W'(accepted);
            if (lane_we[l])
                accepted = accepted + CNT_W'(1);
            for (int unsigned s = 0; s < 2; s++) begin
                lane_tag[l][s] = bus.disp_tag_i[(l*2+s)*TAG_W +: TAG_W];
                {lane_hit[l][s], lane_cdb[l][s]} = cdb_lookup(lane_tag[l][s]);
                lane_rdy[l][s]  = bus.disp_rdy_i[l*2+s] || lane_hit[l][s];
                lane_data[l][s] = bus.disp_rdy_i[l*2+s] ?
                                  bus.disp_data_i[(l*2+s)*DATA_W +: DATA_W] : lane_cdb[l][s];
            end
        end
    end

    // Head readiness and operand selection for the issue register
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
`ifdef LSU_IQ_CDB_BYPASS_EN
            head_src_rdy[s] = ent_rdy[head][s] || wake_hit[head][s];
            head_src[s]     = ent_rdy[head][s] ? ent_data[head][s] : wake_data[head][s];
`else
            head_src_rdy[s] = ent_rdy[head][s];
            head_src[s]     = ent_data[head][s];
`endif
        end
        head_ok  = ent_valid[head] && head_src_rdy[0] && head_src_rdy[1];
        iss_load = head_ok && (!iss_valid || bus.iss_ready_i);
    end

    // Entry state: wakeup latch, free on issue, write on dispatch
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            for (int unsigned e = 0; e < DEPTH; e++)
                ent_valid[e] <= 1'b0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    if (wake_hit[e][s]) begin
                        ent_rdy[e][s]  <= 1'b1;
                        ent_data[e][s] <= wake_data[e][s];
                    end
                end
            end
            if (iss_load)
                ent_valid[head] <= 1'b0;
            // Dispatch slots are always free entries, so they never collide with head or wakeup.
            for (int unsigned l = 0; l < DISPATCH_W; l++) begin
                if (lane_we[l]) begin
                    ent_valid[lane_idx[l]]   <= 1'b1;
                    ent_payload[lane_idx[l]] <= bus.disp_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
                    ent_imm[lane_idx[l]]     <= bus.disp_imm_i[l*DATA_W +: DATA_W];
                    for (int unsigned s = 0; s < 2; s++) begin
                        ent_tag[lane_idx[l]][s]  <= lane_tag[l][s];
                        ent_rdy[lane_idx[l]][s]  <= lane_rdy[l][s];
                        ent_data[lane_idx[l]][s] <= lane_data[l][s];
                    end
                end
            end
        end
    end

    // Head/tail pointers and free-entry counter
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            head     <= '0;
            tail     <= '0;
            free_cnt <= CNT_W'(DEPTH);
        end else begin
            head     <= head + PTR_W'(iss_load);
            tail     <= tail + PTR_W'(accepted);
            free_cnt <= free_cnt - accepted + CNT_W'(iss_load);
        end
    end

    // Registered issue port: load from head, hold while stalled, drop when accepted
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            iss_valid   <= 1'b0;
            iss_vaddr   <= '0;
            iss_wdata   <= '0;
            iss_payload <= '0;
        end else if (iss_load) begin
            iss_valid   <= 1'b1;
            iss_vaddr   <= head_src[1] + ent_imm[head];
            iss_wdata   <= head_src[0];
            iss_payload <= ent_payload[head];
        end else if (bus.iss_ready_i) begin
            iss_valid   <= 1'b0;
        end
    end

    assign bus.disp_ready_o  = disp_ready;
    assign bus.iss_valid_o   = iss_valid;
    assign bus.iss_vaddr_o   = iss_vaddr;
    assign bus.iss_wdata_o   = iss_wdata;
    assign bus.iss_payload_o = iss_payload;
    assign bus.free_cnt_o    = free_cnt;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Self-checking bench for lsu_issue_queue: table of single-op vectors plus directed
// sequences for fill/stall, CDB wakeup ordering, wrap-around streaming and flush.
module tb_lsu_issue_queue;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned DISPATCH_W = 2;
    localparam int unsigned CDB_COUNT  = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned TAG_W      = 6;
    localparam int unsigned PAYLOAD_W  = 64;
    localparam int unsigned NSTREAM    = 3 * DEPTH;

    typedef struct packed {
        logic [63:0] payload;
        logic [31:0] src0;
        logic [31:0] src1;
        logic [31:0] imm;
        logic [31:0] exp_vaddr;
        logic [31:0] exp_wdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    lsu_issue_queue_if #(
        .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .CDB_COUNT(CDB_COUNT),
        .DATA_W(DATA_W), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
    ) bus ();

    lsu_issue_queue #(
        .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .CDB_COUNT(CDB_COUNT),
        .DATA_W(DATA_W), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush_i        = 1'b0;
        bus.disp_valid_i   = '0;
        bus.disp_payload_i = '0;
        bus.disp_imm_i     = '0;
        bus.disp_tag_i     = '0;
        bus.disp_rdy_i     = '0;
        bus.disp_data_i    = '0;
        bus.cdb_valid_i    = '0;
        bus.cdb_tag_i      = '0;
        bus.cdb_data_i     = '0;
    endtask

    task automatic set_lane(input int unsigned l, input logic [63:0] pl, input logic [31:0] imm,
                            input logic [5:0] t0, input logic r0, input logic [31:0] d0,
                            input logic [5:0] t1, input logic r1, input logic [31:0] d1);
        bus.disp_valid_i[l]                       = 1'b1;
        bus.disp_payload_i[l*PAYLOAD_W +: PAYLOAD_W] = pl;
        bus.disp_imm_i[l*DATA_W +: DATA_W]        = imm;
        bus.disp_tag_i[(2*l)*TAG_W +: TAG_W]      = t0;
        bus.disp_tag_i[(2*l+1)*TAG_W +: TAG_W]    = t1;
        bus.disp_rdy_i[2*l]                       = r0;
        bus.disp_rdy_i[2*l+1]                     = r1;
        bus.disp_data_i[(2*l)*DATA_W +: DATA_W]   = d0;
        bus.disp_data_i[(2*l+1)*DATA_W +: DATA_W] = d1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        logic [31:0] q_vaddr [$];
        logic [31:0] q_wdata [$];
        logic [63:0] q_pl    [$];
        int unsigned sent;
        int unsigned recvd;
        logic [31:0] ev, ew;
        logic [63:0] ep;

        // payload, src0, src1, imm, exp_vaddr, exp_wdata
        vecs[0] = '{64'h0000_0000_0000_00A5, 32'h0000_0000, 32'h0000_1000, 32'h0000_0020, 32'h0000_1020, 32'h0000_0000};
        vecs[1] = '{64'h1234_5678_9ABC_DEF0, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[2] = '{64'h0000_0000_0000_003C, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0055};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0001};
        vecs[4] = '{64'h0F0F_0000_0000_1111, 32'h1357_9BDF, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1233, 32'h1357_9BDF};
        vecs[5] = '{64'h0000_0001_0000_0000, 32'hCAFE_F00D, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D};

        // Reset
        clear_inputs();
        bus.iss_ready_i = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_free_cnt",   64'(bus.free_cnt_o),    64'd8);
        check("rst_disp_ready", 64'(bus.disp_ready_o),  64'd1);
        check("rst_iss_valid",  64'(bus.iss_valid_o),   64'd0);
        check("rst_vaddr",      64'(bus.iss_vaddr_o),   64'd0);
        check("rst_wdata",      64'(bus.iss_wdata_o),   64'd0);
        check("rst_payload",    bus.iss_payload_o,      64'd0);

        // Single-op vectors: ready at dispatch, valid two cycles later
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            bus.iss_ready_i = 1'b0;
            set_lane(0, vecs[i].payload, vecs[i].imm, 6'd0, 1'b1, vecs[i].src0, 6'd0, 1'b1, vecs[i].src1);
            step();
            clear_inputs();
            check($sformatf("v%0d_n1_valid", i), 64'(bus.iss_valid_o), 64'd0);
            check($sformatf("v%0d_n1_free", i),  64'(bus.free_cnt_o),  64'd7);
            step();
            check($sformatf("v%0d_valid", i),   64'(bus.iss_valid_o), 64'd1);
            check($sformatf("v%0d_vaddr", i),   64'(bus.iss_vaddr_o), 64'(vecs[i].exp_vaddr));
            check($sformatf("v%0d_wdata", i),   64'(bus.iss_wdata_o), 64'(vecs[i].exp_wdata));
            check($sformatf("v%0d_payload", i), bus.iss_payload_o,    vecs[i].payload);
            check($sformatf("v%0d_free", i),    64'(bus.free_cnt_o),  64'd8);
            bus.iss_ready_i = 1'b1;
            step();
            check($sformatf("v%0d_accepted", i), 64'(bus.iss_valid_o), 64'd0);
            bus.iss_ready_i = 1'b0;
        end

        // Fill with the LSU stalled; queue saturates and later lanes are ignored
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            check($sformatf("fill%0d_disp_ready", k), 64'(bus.disp_ready_o), 64'd1);
            for (int l = 0; l < 2; l++) begin
                int unsigned n;
                n = 32'(2*k + l);
                set_lane(l, 64'h100 + 64'(n), 32'(n*4), 6'd0, 1'b1, 32'hA000 + n, 6'd0, 1'b1, 32'h1000 * (n+1));
            end
            step();
        end
        clear_inputs();
        check("full_disp_ready", 64'(bus.disp_ready_o), 64'd0);
        check("full_free_cnt",   64'(bus.free_cnt_o),   64'd1);
        for (int k = 0; k < 2; k++) begin
            set_lane(0, 64'hDEAD, 32'h0, 6'd0, 1'b1, 32'hBAD0, 6'd0, 1'b1, 32'hBAD0_0000);
            set_lane(1, 64'hBEEF, 32'h0, 6'd0, 1'b1, 32'hBAD1, 6'd0, 1'b1, 32'hBAD1_0000);
            step();
            check($sformatf("held%0d_valid", k), 64'(bus.iss_valid_o), 64'd1);
            check($sformatf("held%0d_vaddr", k), 64'(bus.iss_vaddr_o), 64'h1000);
            check($sformatf("held%0d_free", k),  64'(bus.free_cnt_o),  64'd1);
        end
        clear_inputs();
        bus.iss_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("drain%0d_valid", n),   64'(bus.iss_valid_o),   64'd1);
            check($sformatf("drain%0d_vaddr", n),   64'(bus.iss_vaddr_o),   64'(32'h1000 * (n+1) + 32'(n*4)));
            check($sformatf("drain%0d_payload", n), bus.iss_payload_o,      64'h100 + 64'(n));
            step();
        end
        check("drain_empty_valid", 64'(bus.iss_valid_o), 64'd0);
        check("drain_empty_free",  64'(bus.free_cnt_o),  64'd8);

        // Head waits on CDB tag 5; younger ready op must not overtake
        clear_inputs();
        set_lane(0, 64'hA, 32'h4,    6'd1, 1'b1, 32'h11, 6'd5, 1'b0, 32'h0);
        set_lane(1, 64'hB, 32'h0,    6'd0, 1'b1, 32'h22, 6'd0, 1'b1, 32'h2000);
        step();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wait%0d_valid", k), 64'(bus.iss_valid_o), 64'd0);
            step();
        end
        bus.cdb_valid_i = 2'b10;
        bus.cdb_tag_i   = {6'd5, 6'd0};
        bus.cdb_data_i  = {32'h40, 32'h0};
        step();
        clear_inputs();
`ifndef LSU_IQ_CDB_BYPASS_EN
        check("wake_m1_valid", 64'(bus.iss_valid_o), 64'd0);
        step();
`endif
        check("wake_head_valid",   64'(bus.iss_valid_o),   64'd1);
        check("wake_head_vaddr",   64'(bus.iss_vaddr_o),   64'h44);
        check("wake_head_wdata",   64'(bus.iss_wdata_o),   64'h11);
        check("wake_head_payload", bus.iss_payload_o,      64'hA);
        step();
        check("wake_young_valid",   64'(bus.iss_valid_o), 64'd1);
        check("wake_young_vaddr",   64'(bus.iss_vaddr_o), 64'h2000);
        check("wake_young_payload", bus.iss_payload_o,    64'hB);
        step();
        check("wake_done_valid", 64'(bus.iss_valid_o), 64'd0);

        // Both sources captured from the CDB in the dispatch cycle itself
        set_lane(0, 64'hC, 32'h10, 6'd7, 1'b0, 32'h0, 6'd9, 1'b0, 32'h0);
        bus.cdb_valid_i = 2'b11;
        bus.cdb_tag_i   = {6'd7, 6'd9};
        bus.cdb_data_i  = {32'h77, 32'h300};
        step();
        clear_inputs();
        check("cap_n1_valid", 64'(bus.iss_valid_o), 64'd0);
        step();
        check("cap_valid", 64'(bus.iss_valid_o), 64'd1);
        check("cap_vaddr", 64'(bus.iss_vaddr_o), 64'h310);
        check("cap_wdata", 64'(bus.iss_wdata_o), 64'h77);
        step();

        // Streaming: stall to fill, then drain while refilling one op per cycle
        clear_inputs();
        bus.iss_ready_i = 1'b0;
        sent  = 0;
        recvd = 0;
        for (int cyc = 0; cyc < 400 && recvd < NSTREAM; cyc++) begin
            clear_inputs();
            bus.iss_ready_i = (cyc >= 12);
            if (sent < NSTREAM && bus.disp_ready_o) begin
                ew = 32'hC0DE_0000 + sent;
                ev = 32'h00F0_0000 + sent * 32'h111;
                set_lane(0, 64'h4000 + 64'(sent), 32'(sent * 8), 6'd0, 1'b1, ew, 6'd0, 1'b1, ev);
                q_vaddr.push_back(ev + 32'(sent * 8));
                q_wdata.push_back(ew);
                q_pl.push_back(64'h4000 + 64'(sent));
                sent++;
            end
            if (bus.iss_valid_o && bus.iss_ready_i) begin
                ev = q_vaddr.pop_front();
                ew = q_wdata.pop_front();
                ep = q_pl.pop_front();
                check($sformatf("s%0d_vaddr", recvd),   64'(bus.iss_vaddr_o), 64'(ev));
                check($sformatf("s%0d_wdata", recvd),   64'(bus.iss_wdata_o), 64'(ew));
                check($sformatf("s%0d_payload", recvd), bus.iss_payload_o,    ep);
                recvd++;
            end
            step();
        end
        clear_inputs();
        check("stream_count", 64'(recvd), 64'(NSTREAM));
        step();
        check("stream_free", 64'(bus.free_cnt_o), 64'd8);

        // Flush while full with the output stalled
        bus.iss_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            set_lane(0, 64'hF0 + 64'(k), 32'h0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h9000 + 32'(k));
            set_lane(1, 64'hF8 + 64'(k), 32'h0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h9100 + 32'(k));
            step();
        end
        clear_inputs();
        check("preflush_valid", 64'(bus.iss_valid_o), 64'd1);
        check("preflush_free",  64'(bus.free_cnt_o),  64'd1);
        bus.flush_i = 1'b1;
        set_lane(0, 64'hEE, 32'h0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'hEEEE);
        step();
        clear_inputs();
        check("flush_valid",      64'(bus.iss_valid_o),  64'd0);
        check("flush_free",       64'(bus.free_cnt_o),   64'd8);
        check("flush_disp_ready", 64'(bus.disp_ready_o), 64'd1);
        check("flush_vaddr",      64'(bus.iss_vaddr_o),  64'd0);
        bus.iss_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("postflush%0d_valid", k), 64'(bus.iss_valid_o), 64'd0);
        end
        set_lane(0, 64'h55, 32'h5, 6'd0, 1'b1, 32'h66, 6'd0, 1'b1, 32'h500);
        step();
        clear_inputs();
        step();
        check("fresh_valid",   64'(bus.iss_valid_o), 64'd1);
        check("fresh_vaddr",   64'(bus.iss_vaddr_o), 64'h505);
        check("fresh_payload", bus.iss_payload_o,    64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
